// File: rtl/cover_toggle_collector.sv
// Sticky toggle-cover collector: reports each first hit once as a global cover index, with bitmap re-dump.
module cover_toggle_collector #(
  parameter int WIDTH       = 3,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 10906,
  parameter int IDX_W       = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  input  logic                         dump_req,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [IDX_W-1:0]             evt_index,
  output logic                         dump_done,
  output logic [$clog2(WIDTH+1)-1:0]   covered_count,
  output logic                         all_covered
);

  // evt_valid/evt_ready: an event transfers on a rising clock edge where both are high;
  // while evt_valid is high and evt_ready low, evt_valid and evt_index hold unchanged.

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hit;
  logic [WIDTH-1:0]   pending;
  logic [WIDTH-1:0]   load_mask;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   low_ptr;
  logic [PTR_W-1:0]   load_ptr;
  logic [CNT_W-1:0]   hit_count;
  logic               slot_free;
  logic               load;

  // Lowest-numbered pending bit wins the output slot.
  always_comb begin
    low_ptr = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (pending[i]) low_ptr = PTR_W'(i);
    end
  end

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit_count = hit_count + CNT_W'(hit[i]);
    end
  end

  always_comb begin
    slot_free = !evt_valid || evt_ready;
    load      = 1'b0;
    load_ptr  = '0;
    if (!clear && slot_free) begin
      if (state == IDLE && |pending) begin
        load     = 1'b1;
        load_ptr = low_ptr;
      end else if (state == DUMP && hit[ptr]) begin
        load     = 1'b1;
        load_ptr = ptr;
      end
    end
    load_mask           = '0;
    load_mask[load_ptr] = load;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      hit           <= '0;
      pending       <= '0;
      ptr           <= '0;
      evt_valid     <= 1'b0;
      evt_index     <= '0;
      dump_done     <= 1'b0;
      covered_count <= '0;
    end else begin
      // The output slot is never touched by clear: a held event waits for its handshake.
      if (load) begin
        evt_valid <= 1'b1;
        evt_index <= IDX_W'(COVER_INDEX) + IDX_W'(load_ptr);
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (clear) begin
        state         <= IDLE;
        hit           <= '0;
        pending       <= '0;
        ptr           <= '0;
        dump_done     <= 1'b0;
        covered_count <= '0;
      end else begin
        hit           <= hit | valid;
        pending       <= (pending | (valid & ~hit)) & ~load_mask;
        covered_count <= hit_count;
        dump_done     <= 1'b0;
        case (state)
          IDLE: begin
            if (dump_req) begin
              state <= DUMP;
              ptr   <= '0;
            end
          end
          DUMP: begin
            if (slot_free) begin
              if (ptr == PTR_W'(WIDTH-1)) begin
                state     <= DONE;
                ptr       <= '0;
                dump_done <= 1'b1;
              end else begin
                ptr <= ptr + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign all_covered = (covered_count == CNT_W'(WIDTH));

`ifndef SYNTHESIS
  index_range_ok: assert property (@(posedge clock) disable iff (reset)
    (COVER_INDEX + WIDTH <= COVER_TOTAL));
  stall_stable: assert property (@(posedge clock) disable iff (reset)
    (evt_valid && !evt_ready) |=> (evt_valid && $stable(evt_index)));
`endif

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: directed timing cases plus randomized bursts/dumps/clears
// against a set-based reference model, with an expected-index queue checked by a monitor.
module tb_cover_toggle_collector;

  localparam int W  = 8;
  localparam int CI = 100;
  localparam int CT = 10906;
  localparam int IW = 32;
  localparam int CW = $clog2(W+1);

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic [W-1:0]  valid     = '0;
  logic          clear     = 1'b0;
  logic          dump_req  = 1'b0;
  logic          evt_ready = 1'b1;
  logic          evt_valid;
  logic [IW-1:0] evt_index;
  logic          dump_done;
  logic [CW-1:0] covered_count;
  logic          all_covered;

  int            checks     = 0;
  int            failures   = 0;
  logic [IW-1:0] exp_q[$];
  int            exp_dd     = 0;
  int            seen_dd    = 0;
  logic [W-1:0]  mhit       = '0;
  int            ready_mode = 0;
  logic          prev_stall = 1'b0;
  logic [IW-1:0] prev_idx   = '0;

  cover_toggle_collector #(
    .WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(CT), .IDX_W(IW)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear), .dump_req(dump_req),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
    .dump_done(dump_done), .covered_count(covered_count), .all_covered(all_covered)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // backpressure driver
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       evt_ready = 1'b1;
        1:       evt_ready = 1'($urandom_range(0, 1));
        default: evt_ready = 1'b0;
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(evt_valid), 32'd1);
        check("stall_index", evt_index, prev_idx);
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got index %0d expected no event (t=%0t)", evt_index, $time);
        end else begin
          check("evt_index", evt_index, exp_q.pop_front());
        end
      end
      if (dump_done) seen_dd++;
      prev_stall = evt_valid && !evt_ready;
      prev_idx   = evt_index;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic burst(input logic [W-1:0] v);
    logic [W-1:0] newb;
    newb = v & ~mhit;
    for (int i = 0; i < W; i++) begin
      if (newb[i]) exp_q.push_back(IW'(CI + i));
    end
    mhit  = mhit | v;
    valid = v;
    tick();
    valid = '0;
  endtask

  task automatic dump(input bit extra);
    for (int i = 0; i < W; i++) begin
      if (mhit[i]) exp_q.push_back(IW'(CI + i));
    end
    exp_dd++;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    if (extra) begin
      tick();
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
    end
  endtask

  task automatic do_clear(input logic [W-1:0] v);
    mhit  = '0;
    clear = 1'b1;
    valid = v;
    tick();
    clear = 1'b0;
    valid = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || seen_dd != exp_dd) && n < 1000) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < 1000), 32'd1);
    repeat (3) tick();
    check("dump_done_count", 32'(seen_dd), 32'(exp_dd));
    check("idle_evt_valid", 32'(evt_valid), 32'd0);
    check("covered_count", 32'(covered_count), 32'($countones(mhit)));
    check("all_covered", 32'(all_covered), 32'(mhit == '1));
  endtask

  initial begin
    #12;
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_index", evt_index, 32'd0);
    check("rst_dump_done", 32'(dump_done), 32'd0);
    check("rst_count", 32'(covered_count), 32'd0);
    check("rst_all_covered", 32'(all_covered), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();

    // single point: two-cycle latency, one-cycle event, count lags hit by a cycle
    ready_mode = 0;
    tick();
    burst(8'b0000_0010);
    @(negedge clock);
    check("t1_early_valid", 32'(evt_valid), 32'd0);
    check("t1_count_lag", 32'(covered_count), 32'd0);
    @(negedge clock);
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_index", evt_index, 32'(CI + 1));
    check("t1_count", 32'(covered_count), 32'd1);
    @(negedge clock);
    check("t1_one_cycle", 32'(evt_valid), 32'd0);
    drain();
    burst(8'b0000_0010);
    drain();
    check("t1_count_again", 32'(covered_count), 32'd1);

    // all points at once: consecutive lowest-first events
    do_clear('0);
    drain();
    burst(8'hFF);
    @(negedge clock);
    check("t2_early_valid", 32'(evt_valid), 32'd0);
    for (int i = 0; i < W; i++) begin
      @(negedge clock);
      check("t2_valid", 32'(evt_valid), 32'd1);
      check("t2_index", evt_index, 32'(CI + i));
    end
    drain();
    check("t2_all_covered", 32'(all_covered), 32'd1);

    // long stall holds the first index, then everything drains in order
    do_clear('0);
    drain();
    ready_mode = 2;
    repeat (2) tick();
    burst(8'hFF);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t3_hold_valid", 32'(evt_valid), 32'd1);
      check("t3_hold_index", evt_index, 32'(CI));
    end
    ready_mode = 0;
    drain();

    // dump of a sparse bitmap, with a second request mid-dump
    do_clear('0);
    drain();
    burst(8'b0000_0101);
    drain();
    dump(1'b1);
    drain();

    // clear while an event is held under stall
    do_clear('0);
    drain();
    ready_mode = 2;
    repeat (2) tick();
    burst(8'b0000_0001);
    repeat (3) tick();
    @(negedge clock);
    check("t5_held_valid", 32'(evt_valid), 32'd1);
    check("t5_held_index", evt_index, 32'(CI));
    tick();
    do_clear(8'b0000_0001);
    check("t5_count_cleared", 32'(covered_count), 32'd0);
    check("t5_still_valid", 32'(evt_valid), 32'd1);
    check("t5_still_index", evt_index, 32'(CI));
    ready_mode = 0;
    drain();
    burst(8'b0000_0001);
    drain();

    // dump with nothing hit
    do_clear('0);
    drain();
    dump(1'b0);
    drain();

    // randomized operations under random backpressure
    ready_mode = 1;
    for (int it = 0; it < 80; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        burst(W'($urandom_range(0, 255)) & W'($urandom_range(0, 255)));
      end else if (op <= 7) begin
        dump(1'($urandom_range(0, 1)));
      end else begin
        do_clear(W'($urandom_range(0, 255)));
      end
      drain();
    end

    // asynchronous reset in the middle of a stalled dump
    ready_mode = 2;
    do_clear('0);
    repeat (2) tick();
    burst(8'b0000_1100);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("t6_pre_valid", 32'(evt_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(evt_valid), 32'd0);
    check("t6_rst_index", evt_index, 32'd0);
    check("t6_rst_dump_done", 32'(dump_done), 32'd0);
    check("t6_rst_count", 32'(covered_count), 32'd0);
    check("t6_rst_all_covered", 32'(all_covered), 32'd0);
    exp_q.delete();
    mhit = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    ready_mode = 0;
    repeat (20) tick();
    check("t6_no_dump_done", 32'(seen_dd), 32'(exp_dd));
    check("t6_idle_valid", 32'(evt_valid), 32'd0);
    check("t6_count", 32'(covered_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
